// File: rtl/apb_node_pkg.sv
// rtl/apb_node_pkg.sv - shared types and constants for the APB peripheral node
package apb_node_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DN_SETUP,
      ST_DN_ACCESS,
      ST_RESP,
      ST_ERR
   } node_state_e;

   localparam int          ERR_CNT_W     = 16;
   localparam logic [31:0] DEF_ERR_RDATA = 32'hBADC_0DE5;

   // Width of the access-phase watchdog; it only has to hold 0..cycles-1.
   function automatic int to_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - priority inclusive-range address decoder
module apb_addr_decoder
   import apb_node_pkg::*;
#(
   parameter int NB_SLAVE       = 5,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int IDX_W          = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1
) (
   input  logic [APB_ADDR_WIDTH-1:0]               addr_i,
   input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
   output logic                                    hit_o,
   output logic [IDX_W-1:0]                        idx_o,
   output logic                                    miss_o
);

   // Scan from the top index down so the lowest matching slave is the last writer.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = NB_SLAVE - 1; i >= 0; i--) begin
         if ((addr_i >= start_addr_i[i]) && (addr_i <= end_addr_i[i])) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(i);
         end
      end
   end

   assign miss_o = ~hit_o;

endmodule

// File: rtl/apb_node_guard.sv
// rtl/apb_node_guard.sv - APB 1-to-N node with decode-miss error, watchdog and error counter
module apb_node_guard
   import apb_node_pkg::*;
#(
   parameter int                        NB_SLAVE       = 5,
   parameter int                        APB_ADDR_WIDTH = 32,
   parameter int                        APB_DATA_WIDTH = 32,
   parameter int                        TIMEOUT_CYCLES = 255,
   parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA      = APB_DATA_WIDTH'(DEF_ERR_RDATA)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [APB_ADDR_WIDTH-1:0]               paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]               pwdata_i,
   input  logic                                    pwrite_i,
   input  logic                                    psel_i,
   input  logic                                    penable_i,
   output logic [APB_DATA_WIDTH-1:0]               prdata_o,
   output logic                                    pready_o,
   output logic                                    pslverr_o,
   input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
   output logic [APB_ADDR_WIDTH-1:0]               paddr_o,
   output logic [APB_DATA_WIDTH-1:0]               pwdata_o,
   output logic                                    pwrite_o,
   output logic [NB_SLAVE-1:0]                     psel_o,
   output logic                                    penable_o,
   input  logic [NB_SLAVE-1:0][APB_DATA_WIDTH-1:0] prdata_i,
   input  logic [NB_SLAVE-1:0]                     pready_i,
   input  logic [NB_SLAVE-1:0]                     pslverr_i,
   output logic                                    timeout_o,
   output logic [ERR_CNT_W-1:0]                    err_count_o
);

   localparam int IDX_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
   localparam int TO_W  = to_w(TIMEOUT_CYCLES);

   node_state_e               state_q, state_d;
   logic [IDX_W-1:0]          idx_q;
   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic [APB_DATA_WIDTH-1:0] wdata_q;
   logic                      write_q;
   logic [APB_DATA_WIDTH-1:0] rdata_q;
   logic                      slverr_q;
   logic [TO_W-1:0]           to_cnt_q;
   logic                      timeout_q;
   logic [ERR_CNT_W-1:0]      err_cnt_q;

   logic                      dec_hit;
   logic                      dec_miss;
   logic [IDX_W-1:0]          dec_idx;

   logic                      dn_active;
   logic                      err_inc;
   logic                      to_expire;
   logic                      sel_ready;
   logic                      sel_slverr;
   logic [APB_DATA_WIDTH-1:0] sel_rdata;

   apb_addr_decoder #(
      .NB_SLAVE       (NB_SLAVE),
      .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
      .IDX_W          (IDX_W)
   ) u_decoder (
      .addr_i       (paddr_i),
      .start_addr_i (start_addr_i),
      .end_addr_i   (end_addr_i),
      .hit_o        (dec_hit),
      .idx_o        (dec_idx),
      .miss_o       (dec_miss)
   );

   assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // One-hot downstream select and response mux for the captured slave index.
   always_comb begin
      psel_o     = '0;
      sel_ready  = 1'b0;
      sel_slverr = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < NB_SLAVE; i++) begin
         if (idx_q == IDX_W'(i)) begin
            psel_o[i]  = dn_active;
            sel_ready  = pready_i[i];
            sel_slverr = pslverr_i[i];
            sel_rdata  = prdata_i[i];
         end
      end
   end

   // State register; reset drops the downstream select immediately via the state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the upstream/downstream handshake outputs.
   always_comb begin
      state_d   = state_q;
      dn_active = 1'b0;
      penable_o = 1'b0;
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      prdata_o  = '0;
      err_inc   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (psel_i && !penable_i) begin
               if (dec_hit) begin
                  state_d = ST_DN_SETUP;
               end else if (dec_miss) begin
                  state_d = ST_ERR;
                  err_inc = 1'b1;
               end
            end
         end
         ST_DN_SETUP: begin
            dn_active = 1'b1;
            state_d   = ST_DN_ACCESS;
         end
         ST_DN_ACCESS: begin
            dn_active = 1'b1;
            penable_o = 1'b1;
            if (sel_ready) begin
               state_d = ST_RESP;
            end else if (to_expire) begin
               state_d = ST_ERR;
               err_inc = 1'b1;
            end
         end
         ST_RESP: begin
            pready_o  = psel_i;
            pslverr_o = psel_i & slverr_q;
            prdata_o  = rdata_q;
            state_d   = ST_IDLE;
         end
         ST_ERR: begin
            pready_o  = psel_i;
            pslverr_o = psel_i;
            prdata_o  = ERR_RDATA;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Transfer capture, watchdog counter, timeout pulse and saturating error count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (psel_i && !penable_i) begin
                  addr_q  <= paddr_i;
                  wdata_q <= pwdata_i;
                  write_q <= pwrite_i;
                  idx_q   <= dec_idx;
               end
            end
            ST_DN_SETUP: begin
               to_cnt_q <= '0;
            end
            ST_DN_ACCESS: begin
               to_cnt_q <= to_cnt_q + 1'b1;
               if (sel_ready) begin
                  rdata_q  <= sel_rdata;
                  slverr_q <= sel_slverr;
               end else if (to_expire) begin
                  timeout_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
         if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   assign paddr_o     = addr_q;
   assign pwdata_o    = wdata_q;
   assign pwrite_o    = write_q;
   assign timeout_o   = timeout_q;
   assign err_count_o = err_cnt_q;

endmodule
